syscall_ctrl: RTL and testbench

Sequencing controller that sits between the processor's decode stage and the system-call unit. It accepts syscall requests (nop, display, exit) through a valid/ready handshake. Display words are buffered in a small FIFO and drained to a console sink port. Exit is serialised: the block drains all pending output, waits a fixed number of cycles, then raises a sticky halt to the bench and processor.

---
 rtl/syscall_ctrl.sv | 149 ++++++++++++++
 tb/tb_syscall_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : syscall_ctrl
// Description : Syscall sequencer between decode and the system-call unit.
//               Buffers display words in a FWFT FIFO toward a console sink and
//               serialises exit (drain, fixed delay, then sticky halt).
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_ctrl #(
    parameter int DATA_W            = 32,
    parameter int FIFO_DEPTH        = 4,
    parameter int EXIT_DRAIN_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sys_valid,
    output logic              sys_ready,
    input  logic [DATA_W-1:0] sys_code,
    input  logic [DATA_W-1:0] sys_arg,
    output logic [DATA_W-1:0] sys_result,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = (EXIT_DRAIN_CYCLES > 1) ? $clog2(EXIT_DRAIN_CYCLES + 1) : 1;

    localparam logic [c_addr_w:0]   c_full      = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one   = c_addr_w'(1);
    localparam logic [c_addr_w:0]   c_occ_one   = (c_addr_w + 1)'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_load  = c_cnt_w'(EXIT_DRAIN_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [DATA_W-1:0]   c_code_disp = DATA_W'(1);
    localparam logic [DATA_W-1:0]   c_code_exit = DATA_W'(2);
    localparam logic [DATA_W-1:0]   c_res_one   = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_halted;
    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_addr_w:0]    r_count;
    logic [DATA_W-1:0]    r_result;

    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Ready depends only on registered state/occupancy, never on out_ready.
    assign w_full    = (r_count == c_full);
    assign sys_ready = (r_state == ST_RUN) && !w_full;
    assign stall     = sys_valid && !sys_ready;
    assign w_accept  = sys_valid && sys_ready;
    assign w_push    = w_accept && (sys_code == c_code_disp);

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;

    assign sys_result = r_result;
    assign halted     = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= sys_arg;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_occ_one;
                2'b01:   r_count <= r_count - c_occ_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_pop) begin
            r_result <= r_result + c_res_one;
        end
    end

    // halted is set on the same edge the FSM enters HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && (sys_code == c_code_exit)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == '0) begin
                        if (EXIT_DRAIN_CYCLES == 0) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_cnt   <= c_cnt_load;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_syscall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_ctrl
// Description : Directed self-checking bench for syscall_ctrl (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_ctrl;

    localparam int DATA_W = 32;
    localparam int EXIT_N = 5;

    logic              clk;
    logic              rst;
    logic              sys_valid;
    logic              sys_ready;
    logic [DATA_W-1:0] sys_code;
    logic [DATA_W-1:0] sys_arg;
    logic [DATA_W-1:0] sys_result;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              halted;

    int n_tests;
    int n_fail;

    syscall_ctrl #(
        .DATA_W            (DATA_W),
        .FIFO_DEPTH        (4),
        .EXIT_DRAIN_CYCLES (EXIT_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sys_valid  (sys_valid),
        .sys_ready  (sys_ready),
        .sys_code   (sys_code),
        .sys_arg    (sys_arg),
        .sys_result (sys_result),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sys_valid = 1'b0; sys_code = '0; sys_arg = '0; out_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (sys_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_during: ready=%b ov=%b halted=%b data=%h, need 1 0 0 0",
                     sys_ready, out_valid, halted, out_data);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (sys_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0 ||
            sys_result !== '0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: ready=%b ov=%b halted=%b res=%0d stall=%b, need 1 0 0 0 0",
                     sys_ready, out_valid, halted, sys_result, stall);
        end
    endtask

    task automatic test_display();
        out_ready = 1'b1;
        sys_valid = 1'b1; sys_code = 32'd1; sys_arg = 32'hDEAD_BEEF;
        n_tests++;
        if (sys_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL display_pre: ready=%b ov=%b, need 1 0", sys_ready, out_valid);
        end
        tick();
        sys_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || sys_result !== 32'd0) begin
            n_fail++;
            $display("FAIL display_out: ov=%b data=%h res=%0d, need 1 deadbeef 0",
                     out_valid, out_data, sys_result);
        end
        tick();
        n_tests++;
        if (sys_result !== 32'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL display_count: res=%0d ov=%b, need 1 0", sys_result, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int got;
        bit sent;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sys_valid = 1'b1; sys_code = 32'd1; sys_arg = DATA_W'(i);
            n_tests++;
            if (sys_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept%0d: ready=%b, need 1", i, sys_ready);
            end
            tick();
        end
        sys_arg = 32'd5;
        repeat (2) begin
            n_tests++;
            if (sys_ready !== 1'b0 || stall !== 1'b1 || out_data !== 32'd1) begin
                n_fail++;
                $display("FAIL bp_full: ready=%b stall=%b head=%0d, need 0 1 1",
                         sys_ready, stall, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        got  = 0;
        sent = 1'b0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (sys_valid && sys_ready) sent = 1'b1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_data !== DATA_W'(got + 1)) begin
                    n_fail++;
                    $display("FAIL bp_order%0d: data=%0d, need %0d", got, out_data, got + 1);
                end
                got++;
            end
            tick();
            if (sent) sys_valid = 1'b0;
        end
        sys_valid = 1'b0;
        // One word from the display test plus five here.
        n_tests++;
        if (got !== 5 || sys_result !== 32'd6 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_final: words=%0d res=%0d ov=%b, need 5 6 0", got, sys_result, out_valid);
        end
    endtask

    task automatic test_nop();
        sys_valid = 1'b1; sys_code = 32'd7; sys_arg = 32'h55;
        n_tests++;
        if (sys_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_accept: ready=%b stall=%b, need 1 0", sys_ready, stall);
        end
        tick();
        sys_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || sys_result !== 32'd6 || sys_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_effect: ov=%b res=%0d ready=%b, need 0 6 1", out_valid, sys_result, sys_ready);
        end
    endtask

    task automatic test_exit_pending();
        logic [DATA_W-1:0] exp_words [3];
        exp_words[0] = 32'hA1; exp_words[1] = 32'hA2; exp_words[2] = 32'hA3;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sys_valid = 1'b1; sys_code = 32'd1; sys_arg = exp_words[i];
            tick();
        end
        sys_code = 32'd2;
        n_tests++;
        if (sys_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_accept: ready=%b, need 1", sys_ready);
        end
        tick();
        sys_code = 32'd1; sys_arg = 32'hBB;
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (sys_ready !== 1'b0 || stall !== 1'b1 || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL exit_hold%0d: ready=%b stall=%b halted=%b, need 0 1 0",
                         c, sys_ready, stall, halted);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
                n_fail++;
                $display("FAIL exit_drain%0d: ov=%b data=%h, need 1 %h", i, out_valid, out_data, exp_words[i]);
            end
            tick();
        end
        for (int k = 0; k < EXIT_N + 1; k++) begin
            n_tests++;
            if (halted !== 1'b0) begin
                n_fail++;
                $display("FAIL exit_early%0d: halted=%b, need 0", k, halted);
            end
            tick();
        end
        n_tests++;
        if (halted !== 1'b1 || stall !== 1'b1 || sys_ready !== 1'b0 ||
            out_valid !== 1'b0 || sys_result !== 32'd9) begin
            n_fail++;
            $display("FAIL exit_halt: halted=%b stall=%b ready=%b ov=%b res=%0d, need 1 1 0 0 9",
                     halted, stall, sys_ready, out_valid, sys_result);
        end
        repeat (3) tick();
        n_tests++;
        if (halted !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_sticky: halted=%b ov=%b, need 1 0", halted, out_valid);
        end
        sys_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sys_valid = 1'b1; sys_code = 32'd2;
        tick();
        sys_valid = 1'b0;
        // DRAIN sees empty and loads 5; two WAIT edges later cnt is 3.
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (halted !== 1'b0 || sys_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_async: halted=%b ready=%b, need 0 1", halted, sys_ready);
        end
        tick();
        rst = 1'b0;
        repeat (EXIT_N + 3) tick();
        n_tests++;
        if (halted !== 1'b0 || sys_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_run: halted=%b ready=%b, need 0 1", halted, sys_ready);
        end
        out_ready = 1'b1;
        sys_valid = 1'b1; sys_code = 32'd1; sys_arg = 32'h1234;
        tick();
        sys_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL midwait_disp: ov=%b data=%h, need 1 1234", out_valid, out_data);
        end
        tick();
        n_tests++;
        if (sys_result !== 32'd1) begin
            n_fail++;
            $display("FAIL midwait_count: res=%0d, need 1", sys_result);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sys_valid = 1'b0;
        sys_code  = '0;
        sys_arg   = '0;
        out_ready = 1'b0;
        test_reset();
        test_display();
        test_backpressure();
        test_nop();
        test_exit_pending();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
